pkt_gen_flow_shaper: RTL

//  Per-flow token-bucket shaper and round-robin scheduler inside pkt_gen_top, directly upstream of the packet builder.

---
 rtl/pkt_gen_pkg.sv | 30 +++
 rtl/pkt_gen_period_timer.sv | 38 +++
 rtl/pkt_gen_flow_shaper.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pkt_gen_pkg.sv
// Shared types and constants for the packet-generator shaper path.
//   flow_idx_t     : flow index for the default 16-flow build
//   pkt_size_t     : packet size in bytes, CRC included
//   token_t        : bucket / token credit width
//   shaper_state_t : scheduler states
package pkt_gen_pkg;

  localparam int unsigned FLOW_CNT_DEF = 16;
  localparam int unsigned FLOW_IDX_W   = $clog2(FLOW_CNT_DEF);
  localparam int unsigned PKT_SIZE_W   = 16;
  localparam int unsigned TOKEN_W      = 32;

  typedef logic [FLOW_IDX_W-1:0] flow_idx_t;
  typedef logic [PKT_SIZE_W-1:0] pkt_size_t;
  typedef logic [TOKEN_W-1:0]    token_t;

  typedef enum logic {
    S_SCAN  = 1'b0,
    S_OFFER = 1'b1
  } shaper_state_t;

  // Smallest legal Ethernet frame including CRC
  localparam pkt_size_t MIN_PKT_SIZE = 16'd64;

  // Written sizes below the minimum frame are raised to it
  function automatic pkt_size_t clamp_size(input pkt_size_t s);
    return (s < MIN_PKT_SIZE) ? MIN_PKT_SIZE : s;
  endfunction

endpackage

// File: rtl/pkt_gen_period_timer.sv
// Free-running refill period timer.
//   clk_i        : system clock
//   rst_i        : asynchronous active-high reset
//   refill_stb_o : one-cycle pulse while the count sits at UPDATE_PERIOD-1
module pkt_gen_period_timer #(
  parameter int unsigned UPDATE_PERIOD = 100
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic refill_stb_o
);

  localparam int unsigned CNT_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(UPDATE_PERIOD - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             stb_q;

  // Wrap the count at the last period cycle
  always_comb begin
    count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
  end

  // Strobe is registered from the next count so it is high exactly while count_q == LAST
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      stb_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      stb_q   <= (count_d == LAST);
    end
  end

  assign refill_stb_o = stb_q;

endmodule

// File: rtl/pkt_gen_flow_shaper.sv
// Per-flow token-bucket shaper with round-robin request scheduler.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   wr_size_*             : per-flow packet size table write port (clamped to MIN_PKT_SIZE)
//   wr_token_*            : per-flow token (bytes per refill period) write port
//   wr_flow_en_*          : per-flow enable write port
//   req_valid_o/flow/size : request to the packet builder, held until req_ready_i
//   req_ready_i           : builder accepts the request
module pkt_gen_flow_shaper
  import pkt_gen_pkg::*;
#(
  parameter int unsigned FLOW_CNT       = 16,
  parameter int unsigned FLOW_CNT_WIDTH = (FLOW_CNT > 1) ? $clog2(FLOW_CNT) : 1,
  parameter int unsigned UPDATE_PERIOD  = 100
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [FLOW_CNT_WIDTH-1:0] wr_size_addr_i,
  input  logic [15:0]               wr_size_data_i,
  input  logic                      wr_size_wr_en_i,
  input  logic [FLOW_CNT_WIDTH-1:0] wr_token_addr_i,
  input  logic [31:0]               wr_token_data_i,
  input  logic                      wr_token_wr_en_i,
  input  logic [FLOW_CNT_WIDTH-1:0] wr_flow_en_addr_i,
  input  logic                      wr_flow_en_data_i,
  input  logic                      wr_flow_en_wr_en_i,
  output logic                      req_valid_o,
  output logic [FLOW_CNT_WIDTH-1:0] req_flow_o,
  output logic [15:0]               req_size_o,
  input  logic                      req_ready_i
);

  localparam int unsigned FCW = FLOW_CNT_WIDTH;
  localparam logic [FCW-1:0] PTR_LAST = FCW'(FLOW_CNT - 1);

  pkt_size_t size_q   [FLOW_CNT];
  token_t    token_q  [FLOW_CNT];
  token_t    bucket_q [FLOW_CNT];
  token_t    bucket_d [FLOW_CNT];
  logic [FLOW_CNT-1:0] en_q;

  shaper_state_t  state_q;
  logic [FCW-1:0] ptr_q;
  logic [FCW-1:0] ptr_inc_c;
  logic           req_valid_q;
  logic [FCW-1:0] req_flow_q;
  pkt_size_t      req_size_q;

  logic      refill_stb;
  logic      cur_en_c;
  pkt_size_t cur_size_c;
  token_t    cur_bucket_c;
  logic      grant_c;
  logic [TOKEN_W:0] sum_c;
  logic [TOKEN_W:0] cap_c;

  pkt_gen_period_timer #(
    .UPDATE_PERIOD (UPDATE_PERIOD)
  ) u_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .refill_stb_o (refill_stb)
  );

  // Select the entry under the scan pointer; explicit compare keeps non-power-of-2 counts in range
  always_comb begin
    cur_en_c     = 1'b0;
    cur_size_c   = '0;
    cur_bucket_c = '0;
    for (int f = 0; f < FLOW_CNT; f++) begin
      if (ptr_q == FCW'(f)) begin
        cur_en_c     = en_q[f];
        cur_size_c   = size_q[f];
        cur_bucket_c = bucket_q[f];
      end
    end
  end

  assign grant_c   = (state_q == S_SCAN) && cur_en_c && (cur_bucket_c >= TOKEN_W'(cur_size_c));
  assign ptr_inc_c = (ptr_q == PTR_LAST) ? '0 : ptr_q + FCW'(1);

  // Bucket next state: refill and debit combine in one 33-bit sum so neither is lost
  always_comb begin
    sum_c = '0;
    cap_c = '0;
    for (int f = 0; f < FLOW_CNT; f++) begin
      sum_c = {1'b0, bucket_q[f]}
            + (refill_stb ? {1'b0, token_q[f]} : (TOKEN_W+1)'(0))
            - ((grant_c && (ptr_q == FCW'(f))) ? (TOKEN_W+1)'(size_q[f]) : (TOKEN_W+1)'(0));
      cap_c = {1'b0, token_q[f]} + (TOKEN_W+1)'(size_q[f]);
      if (refill_stb && (sum_c > cap_c)) begin
        sum_c = cap_c;
      end
      if (!en_q[f]) begin
        bucket_d[f] = '0;
      end else if (sum_c[TOKEN_W]) begin
        bucket_d[f] = '1;
      end else begin
        bucket_d[f] = sum_c[TOKEN_W-1:0];
      end
    end
  end

  // Flow tables and buckets
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q <= '0;
      for (int f = 0; f < FLOW_CNT; f++) begin
        size_q[f]   <= '0;
        token_q[f]  <= '0;
        bucket_q[f] <= '0;
      end
    end else begin
      for (int f = 0; f < FLOW_CNT; f++) begin
        bucket_q[f] <= bucket_d[f];
        if (wr_size_wr_en_i && (wr_size_addr_i == FCW'(f))) begin
          size_q[f] <= clamp_size(wr_size_data_i);
        end
        if (wr_token_wr_en_i && (wr_token_addr_i == FCW'(f))) begin
          token_q[f] <= wr_token_data_i;
        end
        if (wr_flow_en_wr_en_i && (wr_flow_en_addr_i == FCW'(f))) begin
          en_q[f] <= wr_flow_en_data_i;
        end
      end
    end
  end

  // Scheduler: scan one flow per cycle, hold the latched request until accepted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_SCAN;
      ptr_q       <= '0;
      req_valid_q <= 1'b0;
      req_flow_q  <= '0;
      req_size_q  <= '0;
    end else begin
      case (state_q)
        S_SCAN: begin
          if (grant_c) begin
            req_valid_q <= 1'b1;
            req_flow_q  <= ptr_q;
            req_size_q  <= cur_size_c;
            state_q     <= S_OFFER;
          end else begin
            ptr_q <= ptr_inc_c;
          end
        end
        S_OFFER: begin
          if (req_ready_i) begin
            req_valid_q <= 1'b0;
            ptr_q       <= ptr_inc_c;
            state_q     <= S_SCAN;
          end
        end
        default: begin
          state_q <= S_SCAN;
        end
      endcase
    end
  end

  assign req_valid_o = req_valid_q;
  assign req_flow_o  = req_flow_q;
  assign req_size_o  = req_size_q;

endmodule
